button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 153 +++++++++++++++
 tb/tb_button_conditioner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: per-button 2-flop synchronizer, debounce filter,
// registered press/release strobes and optional auto-repeat strobes.
module button_conditioner #(
    parameter int NUM_BTNS        = 4,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_BTNS-1:0] btns_raw,
    output logic [NUM_BTNS-1:0] btns_level,
    output logic [NUM_BTNS-1:0] btns_press,
    output logic [NUM_BTNS-1:0] btns_release,
    output logic [NUM_BTNS-1:0] btns_repeat,
    output logic                any_held
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX < 1) ? 1 : $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    logic [NUM_BTNS-1:0] level_next;
    logic                any_held_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             pressed_sync;
            logic [DB_W-1:0]  db_cnt_reg;
            logic [DB_W-1:0]  db_cnt_next;
            logic             lvl_reg;
            logic             lvl_next;
            logic             press_reg;
            logic             release_reg;
            logic             repeat_reg;
            rpt_state_t       state_reg;
            rpt_state_t       state_next;
            logic [RPT_W-1:0] rpt_cnt_reg;
            logic [RPT_W-1:0] rpt_cnt_next;
            logic             rpt_pulse_next;

            // Synchronizer carries the raw pin level; polarity is normalized after it.
            assign pressed_sync = sync2_reg ^ BTN_ACTIVE_LOW;

            always_comb begin
                lvl_next    = lvl_reg;
                db_cnt_next = '0;
                if (pressed_sync != lvl_reg) begin
                    if (db_cnt_reg == DB_LAST) begin
                        lvl_next = pressed_sync;
                    end else begin
                        db_cnt_next = db_cnt_reg + 1'b1;
                    end
                end
            end

            // Repeat FSM follows the next debounced level so that a falling level
            // cancels any repeat pulse on the same edge as the release strobe.
            always_comb begin
                state_next     = state_reg;
                rpt_cnt_next   = rpt_cnt_reg;
                rpt_pulse_next = 1'b0;
                if (REPEAT_PERIOD == 0 || !lvl_next) begin
                    state_next   = RPT_IDLE;
                    rpt_cnt_next = '0;
                end else begin
                    case (state_reg)
                        RPT_IDLE: begin
                            state_next   = RPT_DELAY;
                            rpt_cnt_next = '0;
                        end
                        RPT_DELAY: begin
                            if (rpt_cnt_reg == DELAY_LAST) begin
                                rpt_pulse_next = 1'b1;
                                rpt_cnt_next   = '0;
                                state_next     = RPT_REPEAT;
                            end else begin
                                rpt_cnt_next = rpt_cnt_reg + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            if (rpt_cnt_reg == PERIOD_LAST) begin
                                rpt_pulse_next = 1'b1;
                                rpt_cnt_next   = '0;
                            end else begin
                                rpt_cnt_next = rpt_cnt_reg + 1'b1;
                            end
                        end
                        default: begin
                            state_next   = RPT_IDLE;
                            rpt_cnt_next = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg   <= BTN_ACTIVE_LOW;
                    sync2_reg   <= BTN_ACTIVE_LOW;
                    db_cnt_reg  <= '0;
                    lvl_reg     <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    repeat_reg  <= 1'b0;
                    state_reg   <= RPT_IDLE;
                    rpt_cnt_reg <= '0;
                end else begin
                    sync1_reg   <= btns_raw[gi];
                    sync2_reg   <= sync1_reg;
                    db_cnt_reg  <= db_cnt_next;
                    lvl_reg     <= lvl_next;
                    press_reg   <= lvl_next & ~lvl_reg;
                    release_reg <= ~lvl_next & lvl_reg;
                    repeat_reg  <= rpt_pulse_next;
                    state_reg   <= state_next;
                    rpt_cnt_reg <= rpt_cnt_next;
                end
            end

            assign level_next[gi]   = lvl_next;
            assign btns_level[gi]   = lvl_reg;
            assign btns_press[gi]   = press_reg;
            assign btns_release[gi] = release_reg;
            assign btns_repeat[gi]  = repeat_reg;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            any_held_reg <= 1'b0;
        end else begin
            any_held_reg <= |level_next;
        end
    end

    assign any_held = any_held_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: debounce latency, bounce rejection,
// auto-repeat timing, simultaneous presses, async reset and repeat-disabled variant.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] raw = 4'hF;

    logic [3:0] lvl0, prs0, rel0, rep0;
    logic       held0;
    logic [3:0] lvl1, prs1, rel1, rep1;
    logic       held1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTNS(4), .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clock(clk), .reset_n(rst_n), .btns_raw(raw),
        .btns_level(lvl0), .btns_press(prs0), .btns_release(rel0),
        .btns_repeat(rep0), .any_held(held0)
    );

    button_conditioner #(
        .NUM_BTNS(4), .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(0)
    ) dut_norpt (
        .clock(clk), .reset_n(rst_n), .btns_raw(raw),
        .btns_level(lvl1), .btns_press(prs1), .btns_release(rel1),
        .btns_repeat(rep1), .any_held(held1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " level"}, {28'd0, lvl0}, 32'd0);
        check({tag, " press"}, {28'd0, prs0}, 32'd0);
        check({tag, " release"}, {28'd0, rel0}, 32'd0);
        check({tag, " repeat"}, {28'd0, rep0}, 32'd0);
        check({tag, " any_held"}, {31'd0, held0}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick(3);
        check_all_zero("reset");
        #2 rst_n = 1'b1;
        tick(10);
        check_all_zero("idle");

        // Clean press on button 0: level/press after 6th edge
        raw = 4'b1110;
        tick(5);
        check("press0 level@5", {28'd0, lvl0}, 32'h0);
        tick(1);
        check("press0 level@6", {28'd0, lvl0}, 32'h1);
        check("press0 press@6", {28'd0, prs0}, 32'h1);
        check("press0 held@6", {31'd0, held0}, 32'h1);
        tick(1);
        check("press0 press@7", {28'd0, prs0}, 32'h0);
        check("press0 level@7", {28'd0, lvl0}, 32'h1);
        raw = 4'hF;
        tick(5);
        check("rel0 level@5", {28'd0, lvl0}, 32'h1);
        tick(1);
        check("rel0 level@6", {28'd0, lvl0}, 32'h0);
        check("rel0 release@6", {28'd0, rel0}, 32'h1);
        check("rel0 held@6", {31'd0, held0}, 32'h0);
        tick(1);
        check("rel0 release@7", {28'd0, rel0}, 32'h0);
        tick(5);

        // Bounce rejection on button 1
        for (int k = 0; k < 16; k++) begin
            raw = (k < 3 || (k >= 4 && k < 7)) ? 4'b1101 : 4'b1111;
            tick(1);
            check($sformatf("bounce[%0d] lvl|prs|rel", k), {20'd0, lvl0, prs0, rel0}, 32'h0);
        end
        tick(5);

        // Auto-repeat on button 2
        raw = 4'b1011;
        tick(6);
        check("rpt2 press", {28'd0, prs0}, 32'h4);
        check("rpt2 press norpt", {28'd0, prs1}, 32'h4);
        for (int k = 1; k <= 46; k++) begin
            logic [3:0] exp_rep;
            if (k == 41) raw = 4'hF;
            tick(1);
            exp_rep = (k >= 20 && k <= 45 && (k - 20) % 5 == 0) ? 4'h4 : 4'h0;
            check($sformatf("rpt2 repeat +%0d", k), {28'd0, rep0}, {28'd0, exp_rep});
            check($sformatf("rpt2 norpt repeat +%0d", k), {28'd0, rep1}, 32'h0);
            if (k == 45) check("rpt2 release@5", {28'd0, rel0}, 32'h0);
            if (k == 46) check("rpt2 release@6", {28'd0, rel0}, 32'h4);
        end
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check($sformatf("rpt2 after release %0d", k), {28'd0, rep0 | prs0 | rel0}, 32'h0);
        end

        // Simultaneous press/release of all buttons
        raw = 4'b0000;
        tick(5);
        check("all held@5", {31'd0, held0}, 32'h0);
        tick(1);
        check("all press", {28'd0, prs0}, 32'hF);
        check("all level", {28'd0, lvl0}, 32'hF);
        check("all held", {31'd0, held0}, 32'h1);
        raw = 4'hF;
        tick(6);
        check("all release", {28'd0, rel0}, 32'hF);
        check("all level off", {28'd0, lvl0}, 32'h0);
        check("all held off", {31'd0, held0}, 32'h0);
        tick(5);

        // Async reset while button 0 is in the repeat phase
        raw = 4'b1110;
        tick(6);
        check("rst press", {28'd0, prs0}, 32'h1);
        tick(25);
        check("rst pre level", {28'd0, lvl0}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst async");
        tick(3);
        check_all_zero("rst held");
        #2 rst_n = 1'b1;
        tick(5);
        check("rst re-press@5", {28'd0, prs0}, 32'h0);
        tick(1);
        check("rst re-press@6", {28'd0, prs0}, 32'h1);
        check("rst re-level@6", {28'd0, lvl0}, 32'h1);
        raw = 4'hF;
        tick(12);

        // Repeat-disabled instance: long hold yields no repeats
        raw = 4'b1110;
        tick(6);
        check("norpt press", {28'd0, prs1}, 32'h1);
        begin
            logic [3:0] rep_seen = 4'h0;
            for (int k = 0; k < 100; k++) begin
                tick(1);
                rep_seen = rep_seen | rep1;
            end
            check("norpt repeat over 100", {28'd0, rep_seen}, 32'h0);
        end
        check("norpt level held", {28'd0, lvl1}, 32'h1);
        raw = 4'hF;
        tick(6);
        check("norpt release", {28'd0, rel1}, 32'h1);
        check("norpt held off", {31'd0, held1}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
